// File: rtl/vme_system_arbiter_if.sv
// vme_system_arbiter_if
// Groups the VME arbitration and data-strobe backplane signals seen by the slot-1
// system controller. All signals are active-low, as they are on the backplane.
//   vme_br_n[3:0]    bus request levels 3..0          (bus -> arbiter)
//   vme_bbsy_n       bus busy                         (bus -> arbiter)
//   vme_ds_n[1:0]    data strobes DS1/DS0             (bus -> arbiter)
//   vme_dtack_n      data acknowledge                 (bus -> arbiter)
//   vme_berr_n       bus error from another source    (bus -> arbiter)
//   vme_bg_out_n     bus grant daisy-chain start      (arbiter -> bus)
//   vme_bclr_n       bus clear to current owner       (arbiter -> bus)
//   vme_berr_out_n   bus-timeout error                (arbiter -> bus)
// Modport master is the arbiter side; modport slave is the backplane side.
interface vme_system_arbiter_if;
  logic [3:0] vme_br_n;
  logic       vme_bbsy_n;
  logic [1:0] vme_ds_n;
  logic       vme_dtack_n;
  logic       vme_berr_n;
  logic [3:0] vme_bg_out_n;
  logic       vme_bclr_n;
  logic       vme_berr_out_n;

  modport master (
    input  vme_br_n, vme_bbsy_n, vme_ds_n, vme_dtack_n, vme_berr_n,
    output vme_bg_out_n, vme_bclr_n, vme_berr_out_n
  );

  modport slave (
    output vme_br_n, vme_bbsy_n, vme_ds_n, vme_dtack_n, vme_berr_n,
    input  vme_bg_out_n, vme_bclr_n, vme_berr_out_n
  );
endinterface

// File: rtl/vme_system_arbiter.sv
// vme_system_arbiter
// VME slot-1 system controller: arbitrates BR3..BR0, starts the BG daisy chains,
// drives BCLR to the current owner (fixed priority only) and times out data strobes
// that nobody answers by asserting BERR.
// Ports:
//   clock        system clock
//   reset        asynchronous, active-low
//   enable       high = slot-1 controller active; low forces IDLE and inactive outputs
//   bus          backplane signals (master modport of vme_system_arbiter_if)
//   grant_level  level of the current or most recent grant
//   arb_busy     high while the arbiter FSM is not IDLE
module vme_system_arbiter #(
  parameter int ROUND_ROBIN   = 0,
  parameter int GRANT_TIMEOUT = 64,
  parameter int BUS_TIMEOUT   = 800,
  parameter int TIMER_WIDTH   = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  vme_system_arbiter_if.master       bus,
  output logic [1:0]                 grant_level,
  output logic                       arb_busy
);

  localparam bit                   RR         = (ROUND_ROBIN != 0);
  localparam logic [TIMER_WIDTH-1:0] GRANT_LAST = TIMER_WIDTH'(GRANT_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] BUS_LAST   = TIMER_WIDTH'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  // Two-flop synchronizer, packed {berr, dtack, ds[1:0], bbsy, br[3:0]}
  logic [8:0] sync1, sync2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {bus.vme_berr_n, bus.vme_dtack_n, bus.vme_ds_n, bus.vme_bbsy_n, bus.vme_br_n};
      sync2 <= sync1;
    end
  end

  logic [3:0] br_act;
  logic       bbsy_act, ds_act, dtack_act, berr_act;

  assign br_act    = ~sync2[3:0];
  assign bbsy_act  = ~sync2[4];
  assign ds_act    = ~&sync2[6:5];
  assign dtack_act = ~sync2[7];
  assign berr_act  = ~sync2[8];

  // Arbiter state
  state_t                 state, state_next;
  logic [1:0]             level, level_next;
  logic [1:0]             ptr, ptr_next;
  logic [TIMER_WIDTH-1:0] gcnt, gcnt_next;
  logic [3:0]             bg_n, bg_n_next;
  logic                   bclr_n, bclr_n_next;

  // Winner selection: walk candidates from lowest to highest priority so the
  // highest-priority active request is the last one written. Fixed priority is
  // the round-robin search with the pointer pinned at 3.
  logic [1:0] pick, base, cand;
  logic       above;

  always_comb begin
    pick = '0;
    cand = '0;
    base = RR ? ptr : 2'd3;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = base - 2'(3 - k);
      if (br_act[cand]) pick = cand;
    end
  end

  assign above = |(br_act >> ({1'b0, level} + 3'd1));

  always_comb begin
    state_next  = state;
    level_next  = level;
    ptr_next    = ptr;
    gcnt_next   = gcnt;
    bg_n_next   = bg_n;
    bclr_n_next = bclr_n;
    if (!enable) begin
      state_next  = IDLE;
      level_next  = 2'd3;
      ptr_next    = 2'd3;
      gcnt_next   = '0;
      bg_n_next   = '1;
      bclr_n_next = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!bbsy_act && |br_act) begin
            level_next = pick;
            bg_n_next  = ~(4'b0001 << pick);
            gcnt_next  = '0;
            state_next = GRANT;
          end
        end
        GRANT: begin
          // BBSY is tested first so it wins over a simultaneous withdrawal
          if (bbsy_act) begin
            state_next = BUSY;
            bg_n_next  = '1;
          end else if (!br_act[level] || gcnt == GRANT_LAST) begin
            state_next = IDLE;
            bg_n_next  = '1;
          end else begin
            gcnt_next = gcnt + TIMER_WIDTH'(1);
          end
        end
        BUSY: begin
          bclr_n_next = !(!RR && above);
          if (!bbsy_act) begin
            state_next  = IDLE;
            bclr_n_next = 1'b1;
            if (RR) ptr_next = level - 2'd1;
          end
        end
        default: begin
          state_next  = IDLE;
          bg_n_next   = '1;
          bclr_n_next = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      level  <= 2'd3;
      ptr    <= 2'd3;
      gcnt   <= '0;
      bg_n   <= '1;
      bclr_n <= 1'b1;
    end else begin
      state  <= state_next;
      level  <= level_next;
      ptr    <= ptr_next;
      gcnt   <= gcnt_next;
      bg_n   <= bg_n_next;
      bclr_n <= bclr_n_next;
    end
  end

  // Bus timer, independent of the arbiter FSM
  logic [TIMER_WIDTH-1:0] bcnt, bcnt_next;
  logic                   berr_out_n, berr_out_n_next;

  always_comb begin
    bcnt_next       = bcnt;
    berr_out_n_next = berr_out_n;
    if (!enable || !ds_act) begin
      bcnt_next       = '0;
      berr_out_n_next = 1'b1;
    end else if (berr_out_n) begin
      // Once asserted, BERR holds (and the count saturates) until the strobes go away
      if (dtack_act || berr_act) begin
        bcnt_next = '0;
      end else if (bcnt == BUS_LAST) begin
        berr_out_n_next = 1'b0;
      end else begin
        bcnt_next = bcnt + TIMER_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcnt       <= '0;
      berr_out_n <= 1'b1;
    end else begin
      bcnt       <= bcnt_next;
      berr_out_n <= berr_out_n_next;
    end
  end

  assign bus.vme_bg_out_n   = bg_n;
  assign bus.vme_bclr_n     = bclr_n;
  assign bus.vme_berr_out_n = berr_out_n;
  assign grant_level        = level;
  assign arb_busy           = (state != IDLE);

endmodule

// File: tb/tb_vme_system_arbiter.sv
// tb_vme_system_arbiter
// Drives a fixed-priority and a round-robin arbiter with identical backplane stimulus
// and compares both against a behavioural reference model every clock, plus directed
// vectors and sequences for the grant, clear, timeout and reset scenarios.
module tb_vme_system_arbiter;

  localparam int GT = 64;
  localparam int BT = 800;

  logic clock;
  logic reset;
  logic enable;
  logic [1:0] gl_fp, gl_rr;
  logic       busy_fp, busy_rr;

  vme_system_arbiter_if bus_fp ();
  vme_system_arbiter_if bus_rr ();

  vme_system_arbiter #(.ROUND_ROBIN(0), .GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT), .TIMER_WIDTH(10)) dut_fp (
    .clock(clock), .reset(reset), .enable(enable), .bus(bus_fp),
    .grant_level(gl_fp), .arb_busy(busy_fp)
  );

  vme_system_arbiter #(.ROUND_ROBIN(1), .GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT), .TIMER_WIDTH(10)) dut_rr (
    .clock(clock), .reset(reset), .enable(enable), .bus(bus_rr),
    .grant_level(gl_rr), .arb_busy(busy_rr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] in_br;
  logic       in_bbsy, in_dtack, in_berr;
  logic [1:0] in_ds;

  task automatic drive(input logic [3:0] br, input logic bbsy, input logic [1:0] ds,
                       input logic dtack, input logic berr);
    in_br = br; in_bbsy = bbsy; in_ds = ds; in_dtack = dtack; in_berr = berr;
    bus_fp.vme_br_n = br; bus_fp.vme_bbsy_n = bbsy; bus_fp.vme_ds_n = ds;
    bus_fp.vme_dtack_n = dtack; bus_fp.vme_berr_n = berr;
    bus_rr.vme_br_n = br; bus_rr.vme_bbsy_n = bbsy; bus_rr.vme_ds_n = ds;
    bus_rr.vme_dtack_n = dtack; bus_rr.vme_berr_n = berr;
  endtask

  task automatic clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- reference model ----------------
  // Inputs become visible after two sampling edges (a queue of pending samples).
  // Per mode m (0 fixed, 1 round-robin): offer = level whose BG is low (-1 none),
  // owned = someone holds BBSY after our grant, waited = clocks BG has been held.
  logic [8:0] pipe[$];
  int  m_offer[2], m_waited[2], m_last[2], m_next[2];
  bit  m_owned[2], m_bclr[2];
  int  m_run;
  bit  m_flag;

  task automatic model_clear(input int m);
    m_offer[m] = -1; m_owned[m] = 0; m_waited[m] = 0;
    m_last[m] = 3; m_next[m] = 3; m_bclr[m] = 0;
  endtask

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(9'h1ff);
    pipe.push_back(9'h1ff);
    model_clear(0);
    model_clear(1);
    m_run = 0;
    m_flag = 0;
  endtask

  task automatic model_step();
    logic [8:0] seen;
    int reqs, base, l, pick;
    bit bbsy, ds_any, reply;
    pipe.push_back({in_berr, in_dtack, in_ds, in_bbsy, in_br});
    seen   = pipe.pop_front();
    reqs   = int'(~seen[3:0]) & 15;
    bbsy   = !seen[4];
    ds_any = (seen[6:5] != 2'b11);
    reply  = !seen[7] || !seen[8];
    for (int m = 0; m < 2; m++) begin
      if (!enable) model_clear(m);
      else if (m_owned[m]) begin
        m_bclr[m] = (m == 0) && ((reqs >> (m_last[m] + 1)) != 0);
        if (!bbsy) begin
          m_owned[m] = 0;
          m_bclr[m] = 0;
          if (m == 1) m_next[m] = (m_last[m] + 3) % 4;
        end
      end else if (m_offer[m] >= 0) begin
        if (bbsy) begin m_offer[m] = -1; m_owned[m] = 1; end
        else if (((reqs >> m_last[m]) & 1) == 0) m_offer[m] = -1;
        else if (m_waited[m] == GT) m_offer[m] = -1;
        else m_waited[m]++;
      end else if (!bbsy && reqs != 0) begin
        base = (m == 1) ? m_next[m] : 3;
        pick = -1;
        for (int k = 0; k < 4; k++) begin
          l = (base - k + 4) % 4;
          if (pick < 0 && ((reqs >> l) & 1) != 0) pick = l;
        end
        m_offer[m] = pick;
        m_last[m] = pick;
        m_waited[m] = 1;
      end
    end
    if (!enable || !ds_any) begin
      m_run = 0;
      m_flag = 0;
    end else if (!m_flag) begin
      if (reply) m_run = 0;
      else begin
        m_run++;
        if (m_run == BT) m_flag = 1;
      end
    end
  endtask

  function automatic logic [11:0] model_out(input int m);
    logic [3:0] bg;
    bg = (m_offer[m] >= 0) ? (4'hf & ~(4'b0001 << m_offer[m])) : 4'hf;
    return {3'b000, bg, !m_bclr[m], !m_flag, 2'(m_last[m]), (m_offer[m] >= 0) || m_owned[m]};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clock) begin
    check("model_fp", {3'b000, bus_fp.vme_bg_out_n, bus_fp.vme_bclr_n, bus_fp.vme_berr_out_n, gl_fp, busy_fp},
          model_out(0));
    check("model_rr", {3'b000, bus_rr.vme_bg_out_n, bus_rr.vme_bclr_n, bus_rr.vme_berr_out_n, gl_rr, busy_rr},
          model_out(1));
  end

  // ---------------- directed test ----------------
  typedef struct {
    logic [3:0] br_n;
    logic [3:0] bg_n;
    logic [1:0] lvl;
  } vec_t;

  vec_t vecs[6];
  int   rr_exp[5] = '{3, 2, 1, 0, 3};

  initial begin
    int lvl;
    bit got, seen_idle, all_low;
    logic [3:0] r_br;
    logic       r_bbsy, r_dtack, r_berr;
    logic [1:0] r_ds;

    vecs[0] = '{4'b0101, 4'b0111, 2'd3};
    vecs[1] = '{4'b1101, 4'b1101, 2'd1};
    vecs[2] = '{4'b1110, 4'b1110, 2'd0};
    vecs[3] = '{4'b1001, 4'b1011, 2'd2};
    vecs[4] = '{4'b0000, 4'b0111, 2'd3};
    vecs[5] = '{4'b1100, 4'b1101, 2'd1};

    model_reset();
    reset = 1'b0;
    enable = 1'b0;
    drive(4'hf, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(2);
    check("rst_bg", {8'h0, bus_fp.vme_bg_out_n}, 12'h00f);
    check("rst_bclr_berr", {10'h0, bus_fp.vme_bclr_n, bus_fp.vme_berr_out_n}, 12'h003);
    check("rst_gl_busy", {9'h0, gl_rr, busy_rr}, 12'h006);
    reset = 1'b1;
    enable = 1'b1;
    clk(4);

    // Single-shot grants with no BBSY: both modes pick the highest active level
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].br_n, 1'b1, 2'b11, 1'b1, 1'b1);
      clk(3);
      check("vec_bg_fp", {8'h0, bus_fp.vme_bg_out_n}, {8'h0, vecs[i].bg_n});
      check("vec_gl_fp", {10'h0, gl_fp}, {10'h0, vecs[i].lvl});
      check("vec_bg_rr", {8'h0, bus_rr.vme_bg_out_n}, {8'h0, vecs[i].bg_n});
      drive(4'hf, 1'b1, 2'b11, 1'b1, 1'b1);
      clk(3);
      check("vec_release_busy", {11'h0, busy_fp}, 12'h000);
      clk(1);
    end

    // BR3+BR1 -> BG3, then BBSY drops the grant
    drive(4'b0101, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(3);
    check("t1_bg", {8'h0, bus_fp.vme_bg_out_n}, 12'h007);
    check("t1_gl", {10'h0, gl_fp}, 12'h003);
    drive(4'b0101, 1'b0, 2'b11, 1'b1, 1'b1);
    clk(3);
    check("t1_bg_off", {8'h0, bus_fp.vme_bg_out_n}, 12'h00f);
    check("t1_busy", {11'h0, busy_fp}, 12'h001);
    drive(4'hf, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(4);

    // Round-robin rotation (enable pulse restores the pointer to 3)
    enable = 1'b0;
    clk(2);
    enable = 1'b1;
    drive(4'h0, 1'b1, 2'b11, 1'b1, 1'b1);
    seen_idle = 1'b1;
    for (int i = 0; i < 5; i++) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        clk(1);
        if (!busy_rr) seen_idle = 1'b1;
        if (bus_rr.vme_bg_out_n != 4'hf) got = 1'b1;
      end
      if (!got) begin
        total_cnt++;
        $display("FAIL rr_grant_wait: no grant within 20 clocks, expected level %0d", rr_exp[i]);
      end else begin
        lvl = 0;
        for (int b = 0; b < 4; b++) if (!bus_rr.vme_bg_out_n[b]) lvl = b;
        check("rr_order", 12'(lvl), 12'(rr_exp[i]));
        check("rr_gap", {11'h0, seen_idle}, 12'h001);
      end
      drive(4'h0, 1'b0, 2'b11, 1'b1, 1'b1);
      clk(5);
      drive(4'h0, 1'b1, 2'b11, 1'b1, 1'b1);
      seen_idle = 1'b0;
    end
    drive(4'hf, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(5);

    // Fixed priority BCLR: BR0 owns the bus, BR2 requests
    drive(4'b1110, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(3);
    check("t3_bg0", {8'h0, bus_fp.vme_bg_out_n}, 12'h00e);
    drive(4'b1110, 1'b0, 2'b11, 1'b1, 1'b1);
    clk(3);
    check("t3_bclr_idle", {11'h0, bus_fp.vme_bclr_n}, 12'h001);
    drive(4'b1010, 1'b0, 2'b11, 1'b1, 1'b1);
    clk(3);
    check("t3_bclr_low", {11'h0, bus_fp.vme_bclr_n}, 12'h000);
    drive(4'b1010, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(3);
    check("t3_bclr_high", {7'h0, bus_fp.vme_bclr_n, bus_fp.vme_bg_out_n}, 12'h01f);
    clk(1);
    check("t3_bg2", {6'h0, gl_fp, bus_fp.vme_bg_out_n}, 12'h02b);
    drive(4'hf, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(4);

    // Grant timeout: BG2 held for GT clocks, one idle clock, then re-granted
    drive(4'b1011, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(3);
    all_low = 1'b1;
    for (int c = 0; c < GT; c++) begin
      if (bus_fp.vme_bg_out_n != 4'b1011) all_low = 1'b0;
      if (c != GT - 1) clk(1);
    end
    check("t4_bg_held", {11'h0, all_low}, 12'h001);
    clk(1);
    check("t4_bg_gap", {8'h0, bus_fp.vme_bg_out_n}, 12'h00f);
    clk(1);
    check("t4_regrant", {8'h0, bus_fp.vme_bg_out_n}, 12'h00b);
    drive(4'hf, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(4);

    // Bus timeout on an unanswered DS0
    drive(4'hf, 1'b1, 2'b10, 1'b1, 1'b1);
    for (int n = 1; n <= BT + 3; n++) begin
      clk(1);
      if (n == BT + 1) check("t5_berr_early", {11'h0, bus_fp.vme_berr_out_n}, 12'h001);
      if (n == BT + 3) check("t5_berr_low", {11'h0, bus_fp.vme_berr_out_n}, 12'h000);
    end
    drive(4'hf, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(3);
    check("t5_berr_release", {11'h0, bus_fp.vme_berr_out_n}, 12'h001);
    drive(4'hf, 1'b1, 2'b10, 1'b1, 1'b1);
    clk(500);
    drive(4'hf, 1'b1, 2'b10, 1'b0, 1'b1);
    clk(400);
    check("t5_dtack_no_berr", {11'h0, bus_rr.vme_berr_out_n}, 12'h001);
    drive(4'hf, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(3);

    // Asynchronous reset while granting with BERR asserted
    drive(4'hf, 1'b1, 2'b10, 1'b1, 1'b1);
    clk(BT + 5);
    drive(4'b1101, 1'b1, 2'b10, 1'b1, 1'b1);
    clk(5);
    check("t6_pre", {6'h0, bus_fp.vme_berr_out_n, bus_fp.vme_bg_out_n}, 12'h00d);
    #2 reset = 1'b0;
    #1;
    check("t6_async_fp", {3'b000, bus_fp.vme_bg_out_n, bus_fp.vme_bclr_n, bus_fp.vme_berr_out_n, gl_fp, busy_fp},
          12'h1fe);
    check("t6_async_rr", {3'b000, bus_rr.vme_bg_out_n, bus_rr.vme_bclr_n, bus_rr.vme_berr_out_n, gl_rr, busy_rr},
          12'h1fe);
    drive(4'hf, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(1);
    reset = 1'b1;
    clk(2);
    drive(4'b1101, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(3);
    check("t6_regrant", {6'h0, gl_fp, bus_fp.vme_bg_out_n}, 12'h01d);
    drive(4'hf, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(4);

    // Randomized traffic, checked every clock by the model comparison
    r_br = 4'hf; r_bbsy = 1'b1; r_ds = 2'b11; r_dtack = 1'b1; r_berr = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) r_br = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) r_bbsy = ~r_bbsy;
      if ($urandom_range(0, 4) == 0) r_ds = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) r_dtack = 1'($urandom_range(0, 1));
      r_berr = ($urandom_range(0, 19) != 0);
      enable = ($urandom_range(0, 99) != 0);
      drive(r_br, r_bbsy, r_ds, r_dtack, r_berr);
      clk(1);
    end
    enable = 1'b1;
    drive(4'hf, 1'b1, 2'b11, 1'b1, 1'b1);
    clk(4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
